// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and constants for the SPI master round-robin controller.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ARB   = 3'd0,
        START = 3'd1,
        XFER  = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam int unsigned CS_GAP_DEFAULT = 2;

    // Cycles from the start pulse until the SPI master has returned to idle.
    function automatic int unsigned xfer_cycles(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester and SPI-master side signals of the shared SPI transceiver controller.
interface spi_master_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;
    logic                          spi_start;
    logic [DATA_WIDTH-1:0]         data_send;
    logic [DATA_WIDTH-1:0]         data_recv;

    // Requesters plus the SPI master, seen from outside the controller.
    modport master (
        output req, req_data, data_recv,
        input  ack, resp_data, grant_id, busy, spi_start, data_send
    );

    // The controller itself.
    modport slave (
        input  req, req_data, data_recv,
        output ack, resp_data, grant_id, busy, spi_start, data_send
    );
endinterface

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after last_grant, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);
    logic [IDX_W-1:0] idx;

    // Scan farthest-first so the nearest requester after last_grant overwrites last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end
endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one mode-0 SPI master between NUM_REQ requesters; times each word by
// cycle count since the SPI master reports neither busy nor done.
module spi_master_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CS_GAP     = CS_GAP_DEFAULT
) (
    input logic clk,
    input logic rst,
    spi_master_arbiter_if.slave bus
);
    localparam int unsigned IDX_W       = $clog2(NUM_REQ);
    localparam int unsigned XFER_CYCLES = xfer_cycles(DATA_WIDTH);
    localparam int unsigned CNT_W       = $clog2(2 * DATA_WIDTH + 2);
    localparam int unsigned GAP_W       = $clog2(CS_GAP + 1);

    localparam logic [2:0] S_ARB   = 3'(ARB);
    localparam logic [2:0] S_START = 3'(START);
    localparam logic [2:0] S_XFER  = 3'(XFER);
    localparam logic [2:0] S_DONE  = 3'(DONE);
    localparam logic [2:0] S_GAP   = 3'(GAP);

    logic [2:0]            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [GAP_W-1:0]      gap, gap_d;
    logic [IDX_W-1:0]      last_grant, last_grant_d;
    logic [IDX_W-1:0]      grant_id, grant_id_d;
    logic [DATA_WIDTH-1:0] data_send, data_send_d;
    logic [DATA_WIDTH-1:0] resp_data, resp_data_d;
    logic [NUM_REQ-1:0]    ack, ack_d;
    logic                  spi_start, spi_start_d;
    logic                  busy, busy_d;

    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (bus.req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // State and registered outputs; reset aborts any word without acking it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_ARB;
            cnt        <= '0;
            gap        <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_id   <= '0;
            data_send  <= '0;
            resp_data  <= '0;
            ack        <= '0;
            spi_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            gap        <= gap_d;
            last_grant <= last_grant_d;
            grant_id   <= grant_id_d;
            data_send  <= data_send_d;
            resp_data  <= resp_data_d;
            ack        <= ack_d;
            spi_start  <= spi_start_d;
            busy       <= busy_d;
        end
    end

    // Next state plus next output values, so every output comes straight from a flop.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        gap_d        = gap;
        last_grant_d = last_grant;
        grant_id_d   = grant_id;
        data_send_d  = data_send;
        resp_data_d  = resp_data;
        ack_d        = '0;
        spi_start_d  = 1'b0;

        case (state)
            S_ARB: begin
                if (grant_valid) begin
                    state_d      = S_START;
                    data_send_d  = bus.req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
                    grant_id_d   = grant_idx;
                    last_grant_d = grant_idx;
                    spi_start_d  = 1'b1;
                end
            end
            S_START: begin
                state_d = S_XFER;
                cnt_d   = CNT_W'(XFER_CYCLES);
            end
            S_XFER: begin
                if (cnt == CNT_W'(1)) begin
                    state_d         = S_DONE;
                    resp_data_d     = bus.data_recv;
                    ack_d[grant_id] = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                gap_d   = GAP_W'(CS_GAP);
            end
            S_GAP: begin
                if (gap == GAP_W'(1)) begin
                    state_d = S_ARB;
                end else begin
                    gap_d = gap - GAP_W'(1);
                end
            end
            default: state_d = S_ARB;
        endcase

        busy_d = (state_d != S_ARB);
    end

    assign bus.ack       = ack;
    assign bus.resp_data = resp_data;
    assign bus.grant_id  = grant_id;
    assign bus.busy      = busy;
    assign bus.spi_start = spi_start;
    assign bus.data_send = data_send;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a behavioural mode-0 SPI master/slave pair.
module tb_spi_master_arbiter;
    localparam int unsigned W = 16;
    localparam int unsigned N = 4;

    logic clk;
    logic rst;

    spi_master_arbiter_if #(.DATA_WIDTH(W), .NUM_REQ(N)) bus ();

    spi_master_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N), .CS_GAP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int start_cnt = 0;
    int overlap   = 0;
    int ack_cnt [N];

    // SPI master + slave model: 2W cycles per word, MOSI bit taken live from data_send.
    logic [W-1:0] slave_word;
    logic [W-1:0] rx_sh;
    logic [W-1:0] mosi_word;
    logic         active;
    int           ph;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            ph     <= 0;
            rx_sh  <= '0;
        end else if (active) begin
            if (bus.spi_start) overlap <= overlap + 1;
            if (ph[0] == 1'b0) begin
                mosi_word <= {mosi_word[W-2:0], bus.data_send[W-1-ph/2]};
                rx_sh     <= {rx_sh[W-2:0], slave_word[W-1-ph/2]};
            end
            ph <= ph + 1;
            if (ph == 2 * W - 1) active <= 1'b0;
        end else if (bus.spi_start) begin
            active    <= 1'b1;
            ph        <= 0;
            mosi_word <= '0;
        end
    end
    assign bus.data_recv = rx_sh;

    initial for (int i = 0; i < N; i++) ack_cnt[i] = 0;

    always @(negedge clk) begin
        if (bus.spi_start) start_cnt++;
        for (int i = 0; i < N; i++) if (bus.ack[i]) ack_cnt[i]++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input string tag, output int at);
        int n = 0;
        while (bus.spi_start !== 1'b1 && n < 300) begin tick(); n++; end
        check({tag, "_start_seen"}, 64'(bus.spi_start), 64'd1);
        at = cyc;
    endtask

    task automatic wait_ack(input string tag, output int at);
        int n = 0;
        while (bus.ack === '0 && n < 300) begin tick(); n++; end
        check({tag, "_ack_seen"}, 64'(|bus.ack), 64'd1);
        at = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 300) begin tick(); n++; end
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},       64'(bus.ack),       64'd0);
        check({tag, "_resp"},      64'(bus.resp_data), 64'd0);
        check({tag, "_grant_id"},  64'(bus.grant_id),  64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_spi_start"}, 64'(bus.spi_start), 64'd0);
        check({tag, "_data_send"}, 64'(bus.data_send), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    int s_at, a_at, prev_at, snap_s, snap_a;

    initial begin
        rst           = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        slave_word    = '0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b1;
        tick();

        // Single request from requester 2.
        bus.req_data[2*W +: W] = 16'hA55A;
        slave_word             = 16'h3C3C;
        bus.req                = 4'b0100;
        wait_start("single", s_at);
        check("single_grant_id", 64'(bus.grant_id), 64'd2);
        check("single_busy", 64'(bus.busy), 64'd1);
        tick();
        check("single_start_pulse", 64'(bus.spi_start), 64'd0);
        wait_ack("single", a_at);
        bus.req = '0;
        check("single_ack_latency", 64'(a_at - s_at), 64'd34);
        check("single_ack_vec", 64'(bus.ack), 64'h4);
        check("single_resp", 64'(bus.resp_data), 64'h3C3C);
        check("single_mosi", 64'(mosi_word), 64'hA55A);
        tick();
        check("single_ack_once", 64'(bus.ack), 64'd0);
        check("single_resp_hold", 64'(bus.resp_data), 64'h3C3C);
        wait_idle("single");

        // All four requesting continuously: strict rotation at fixed spacing.
        do_reset();
        bus.req_data = 64'h4444_3333_2222_1111;
        bus.req      = 4'b1111;
        prev_at      = 0;
        for (int i = 0; i < 8; i++) begin
            wait_start($sformatf("rr%0d", i), s_at);
            check($sformatf("rr%0d_grant", i), 64'(bus.grant_id), 64'(i % 4));
            if (i > 0) check($sformatf("rr%0d_spacing", i), 64'(s_at - prev_at), 64'd38);
            prev_at = s_at;
            tick();
        end
        bus.req = '0;
        wait_idle("rr");

        // Make last_grant = 1, then requesters 0 and 3 rise together.
        bus.req = 4'b0010;
        wait_ack("prep", a_at);
        bus.req = '0;
        wait_idle("prep");
        bus.req = 4'b1001;
        wait_start("same_first", s_at);
        check("same_first_grant", 64'(bus.grant_id), 64'd3);
        wait_ack("same_first", a_at);
        bus.req[3] = 1'b0;
        wait_start("same_second", s_at);
        check("same_second_grant", 64'(bus.grant_id), 64'd0);
        wait_ack("same_second", a_at);
        bus.req = '0;
        wait_idle("same");

        // Requester 2 pulses req only while the port is busy: never served.
        snap_a  = ack_cnt[2];
        bus.req = 4'b0001;
        wait_start("drop_pre", s_at);
        repeat (3) tick();
        bus.req[2] = 1'b1;
        repeat (3) tick();
        bus.req[2] = 1'b0;
        wait_ack("drop_pre", a_at);
        bus.req = '0;
        snap_s  = start_cnt;
        repeat (60) tick();
        check("drop_pre_no_start", 64'(start_cnt - snap_s), 64'd0);
        check("drop_pre_no_ack", 64'(ack_cnt[2] - snap_a), 64'd0);

        // Requester 1 drops req mid-transfer: ack still arrives.
        bus.req = 4'b0010;
        wait_start("drop_mid", s_at);
        repeat (5) tick();
        bus.req = '0;
        wait_ack("drop_mid", a_at);
        check("drop_mid_ack_vec", 64'(bus.ack), 64'h2);
        check("drop_mid_latency", 64'(a_at - s_at), 64'd34);
        snap_s = start_cnt;
        repeat (50) tick();
        check("drop_mid_no_restart", 64'(start_cnt - snap_s), 64'd0);

        // Reset in cycle 10 of a transfer.
        bus.req = 4'b0100;
        wait_start("rst_mid", s_at);
        repeat (9) tick();
        snap_a = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (3) tick();
        bus.req = 4'b0101;
        rst     = 1'b1;
        wait_start("rst_next", s_at);
        check("rst_no_ack", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3] - snap_a), 64'd0);
        check("rst_next_grant", 64'(bus.grant_id), 64'd0);
        wait_ack("rst_next", a_at);
        check("rst_next_ack_vec", 64'(bus.ack), 64'h1);
        bus.req = '0;
        wait_idle("rst_next");

        // req_data changes after grant: the latched word still goes out.
        bus.req_data[1*W +: W] = 16'h1234;
        slave_word             = 16'h5678;
        bus.req                = 4'b0010;
        wait_start("late_data", s_at);
        tick();
        bus.req_data[1*W +: W] = 16'hFFFF;
        wait_ack("late_data", a_at);
        bus.req = '0;
        check("late_data_mosi", 64'(mosi_word), 64'h1234);
        check("late_data_send", 64'(bus.data_send), 64'h1234);
        check("late_data_resp", 64'(bus.resp_data), 64'h5678);
        wait_idle("late_data");

        check("no_start_mid_word", 64'(overlap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
